// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/stall control logic.
// Latency: n/a (declarations only).
// Backpressure: n/a. Port summary: none (package).
package pipe_ctrl_pkg;

    localparam int REG_W    = 4;   // register specifier width
    localparam int STALLC_W = 2;   // width of the control-flush countdown

    // A NOP is injected into a pipeline latch by clearing its valid bit.
    localparam logic NOP_VALID = 1'b0;

    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_BUSY = 1'b1
    } md_state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter: adds one per cycle while inc is high, sticks at all-ones.
// Latency: count reflects inc one clock edge later.
// Backpressure: none; ports clk, reset (async active-low), inc, count[CNT_W-1:0].
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/hazard_control_unit.sv
// Hazard control: RAW, taken-branch flush and mul/div occupancy -> stall/stallC/bubbleE/flushD.
// Latency: stall/bubbleE/flushD combinational from inputs + state; stallC and counters registered.
// Backpressure: stall holds PC and Fetch->Decode; control flush overrides any stall.
// Ports: clk, reset (async active-low); Decode sources (validD, srcAD/BD, readsAD/BD);
//        Execute info (validE, rdE, isWbE, isMulDivE, branchTakenE); controls and counters out.
module hazard_control_unit
    import pipe_ctrl_pkg::*;
#(
    parameter int FLUSH_CYCLES = 2,
    parameter int MULDIV_LAT   = 4,
    parameter int CNT_W        = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                validD,
    input  logic [REG_W-1:0]    srcAD,
    input  logic [REG_W-1:0]    srcBD,
    input  logic                readsAD,
    input  logic                readsBD,
    input  logic                validE,
    input  logic [REG_W-1:0]    rdE,
    input  logic                isWbE,
    input  logic                isMulDivE,
    input  logic                branchTakenE,
    output logic                stall,
    output logic [STALLC_W-1:0] stallC,
    output logic                bubbleE,
    output logic                flushD,
    output logic [CNT_W-1:0]    dataStallCnt,
    output logic [CNT_W-1:0]    ctrlFlushCnt,
    output logic [CNT_W-1:0]    mdStallCnt
);

    localparam logic [STALLC_W-1:0] FLUSH_LOAD = STALLC_W'(FLUSH_CYCLES);
    localparam bit                  MD_EN      = (MULDIV_LAT > 1);
    // The first stall cycle is spent in MD_IDLE, so BUSY counts LAT-2 more.
    localparam logic [3:0]          MD_INIT    = (MULDIV_LAT > 1) ? 4'(MULDIV_LAT - 2) : 4'd0;

    md_state_t  md_state, md_state_n;
    logic [3:0] md_cnt, md_cnt_n;

    logic dh;
    logic branch_det;
    logic flushing;
    logic md_start;
    logic md_stall;

    // ---------------- hazard detection ----------------
    assign dh = validD & validE & isWbE &
                ((readsAD & (srcAD == rdE)) | (readsBD & (srcBD == rdE)));

    // A new taken branch is only accepted once the previous flush has drained.
    assign branch_det = (stallC == '0) & validE & branchTakenE;
    assign flushing   = (stallC != '0) | branch_det;

    // A taken branch in Execute wins over a mul/div claiming the same slot.
    assign md_start = MD_EN & validE & isMulDivE & ~branch_det;

    // ---------------- mul/div FSM: state register ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            md_state <= MD_IDLE;
            md_cnt   <= '0;
        end else begin
            md_state <= md_state_n;
            md_cnt   <= md_cnt_n;
        end
    end

    // ---------------- mul/div FSM: next state ----------------
    always_comb begin
        md_state_n = md_state;
        md_cnt_n   = md_cnt;
        unique case (md_state)
            MD_IDLE: begin
                if (md_start) begin
                    md_state_n = MD_BUSY;
                    md_cnt_n   = MD_INIT;
                end
            end
            MD_BUSY: begin
                // Leaving at md_cnt==0 lets the finished op drain; the next
                // instruction is examined fresh from MD_IDLE.
                if (branch_det || (md_cnt == '0)) begin
                    md_state_n = MD_IDLE;
                    md_cnt_n   = '0;
                end else begin
                    md_cnt_n   = md_cnt - 4'd1;
                end
            end
            default: begin
                md_state_n = MD_IDLE;
                md_cnt_n   = '0;
            end
        endcase
    end

    // ---------------- mul/div FSM: outputs ----------------
    always_comb begin
        md_stall = 1'b0;
        unique case (md_state)
            MD_IDLE: md_stall = md_start;
            MD_BUSY: md_stall = (md_cnt != '0) & ~branch_det;
            default: md_stall = 1'b0;
        endcase
    end

    // ---------------- control-flush countdown ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stallC <= '0;
        end else if (branch_det) begin
            stallC <= FLUSH_LOAD;
        end else if (stallC != '0) begin
            stallC <= stallC - STALLC_W'(1);
        end
    end

    // ---------------- combined controls ----------------
    assign stall   = (dh | md_stall) & ~flushing;
    assign bubbleE = flushing | (dh & ~md_stall);
    assign flushD  = flushing;

    // ---------------- performance counters ----------------
    sat_counter #(.CNT_W(CNT_W)) u_data_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (dh & ~md_stall & ~flushing),
        .count (dataStallCnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_ctrl_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (stallC != '0),
        .count (ctrlFlushCnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_md_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (md_stall & ~flushing),
        .count (mdStallCnt)
    );

endmodule

// File: tb/tb_hazard_control_unit.sv
// Directed bench for hazard_control_unit: expectations queued per step, popped at mid-cycle.
// A second instance (CNT_W=2, MULDIV_LAT=1) shares the inputs for saturation and no-stall checks.
module tb_hazard_control_unit;
    import pipe_ctrl_pkg::*;

    logic        clk, reset;
    logic        validD, readsAD, readsBD, validE, isWbE, isMulDivE, branchTakenE;
    logic [3:0]  srcAD, srcBD, rdE;

    logic        stall, bubbleE, flushD;
    logic [1:0]  stallC;
    logic [15:0] dataStallCnt, ctrlFlushCnt, mdStallCnt;

    logic        stall2, bubbleE2, flushD2;
    logic [1:0]  stallC2;
    logic [1:0]  dcnt2, ccnt2, mcnt2;

    hazard_control_unit dut (
        .clk(clk), .reset(reset),
        .validD(validD), .srcAD(srcAD), .srcBD(srcBD), .readsAD(readsAD), .readsBD(readsBD),
        .validE(validE), .rdE(rdE), .isWbE(isWbE), .isMulDivE(isMulDivE),
        .branchTakenE(branchTakenE),
        .stall(stall), .stallC(stallC), .bubbleE(bubbleE), .flushD(flushD),
        .dataStallCnt(dataStallCnt), .ctrlFlushCnt(ctrlFlushCnt), .mdStallCnt(mdStallCnt)
    );

    hazard_control_unit #(.FLUSH_CYCLES(2), .MULDIV_LAT(1), .CNT_W(2)) dut2 (
        .clk(clk), .reset(reset),
        .validD(validD), .srcAD(srcAD), .srcBD(srcBD), .readsAD(readsAD), .readsBD(readsBD),
        .validE(validE), .rdE(rdE), .isWbE(isWbE), .isMulDivE(isMulDivE),
        .branchTakenE(branchTakenE),
        .stall(stall2), .stallC(stallC2), .bubbleE(bubbleE2), .flushD(flushD2),
        .dataStallCnt(dcnt2), .ctrlFlushCnt(ccnt2), .mdStallCnt(mcnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic        st;
        logic [1:0]  sc;
        logic        bub;
        logic        fl;
        logic [15:0] d, c, m;
        bit          chk2;
        logic        s2;
        logic [1:0]  d2, m2;
    } exp_t;

    exp_t sb[$];
    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [15:0] obs, input logic [15:0] exp_v);
        checks++;
        assert (obs === exp_v)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp_v);
        end
    endtask

    task automatic expect_out(input string tag, input logic st, input logic [1:0] sc,
                              input logic bub, input logic fl, input int d, input int c,
                              input int m, input bit c2 = 1'b0, input logic s2 = 1'b0,
                              input int d2 = 0, input int m2 = 0);
        exp_t e;
        e.tag  = tag;
        e.st   = st;
        e.sc   = sc;
        e.bub  = bub;
        e.fl   = fl;
        e.d    = 16'(d);
        e.c    = 16'(c);
        e.m    = 16'(m);
        e.chk2 = c2;
        e.s2   = s2;
        e.d2   = 2'(d2);
        e.m2   = 2'(m2);
        sb.push_back(e);
    endtask

    task automatic check_now();
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $error("FAIL scoreboard_empty observed=0 entries expected=1 entry");
        end else begin
            e = sb.pop_front();
            chk({e.tag, "/stall"},   16'(stall),   16'(e.st));
            chk({e.tag, "/stallC"},  16'(stallC),  16'(e.sc));
            chk({e.tag, "/bubbleE"}, 16'(bubbleE), 16'(e.bub));
            chk({e.tag, "/flushD"},  16'(flushD),  16'(e.fl));
            chk({e.tag, "/dataCnt"}, dataStallCnt, e.d);
            chk({e.tag, "/ctrlCnt"}, ctrlFlushCnt, e.c);
            chk({e.tag, "/mdCnt"},   mdStallCnt,   e.m);
            if (e.chk2) begin
                chk({e.tag, "/u2_stall"},   16'(stall2),   16'(e.s2));
                chk({e.tag, "/u2_bubbleE"}, 16'(bubbleE2), 16'(e.s2));
                chk({e.tag, "/u2_flushD"},  16'(flushD2),  16'(0));
                chk({e.tag, "/u2_stallC"},  16'(stallC2),  16'(0));
                chk({e.tag, "/u2_dataCnt"}, 16'(dcnt2),    16'(e.d2));
                chk({e.tag, "/u2_ctrlCnt"}, 16'(ccnt2),    16'(0));
                chk({e.tag, "/u2_mdCnt"},   16'(mcnt2),    16'(e.m2));
            end
        end
    endtask

    // Inputs are applied 1 time unit after a rising edge; outputs are checked 2 units later.
    task automatic step();
        #2;
        check_now();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic vD, input logic [3:0] sA, input logic rA,
                         input logic [3:0] sB, input logic rB, input logic vE,
                         input logic [3:0] rd, input logic wb, input logic md, input logic br);
        validD       = vD;
        srcAD        = sA;
        readsAD      = rA;
        srcBD        = sB;
        readsBD      = rB;
        validE       = vE;
        rdE          = rd;
        isWbE        = wb;
        isMulDivE    = md;
        branchTakenE = br;
    endtask

    task automatic idle();
        drive(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        reset = 1'b0;
        idle();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;

        // Reset state and data hazards
        idle();                                                   expect_out("idle",      0, 0, 0, 0, 0, 0, 0); step();
        drive(1, 4'd3, 1, 4'd0, 0, 1, 4'd3, 1, 0, 0);             expect_out("rawA",      1, 0, 1, 0, 0, 0, 0); step();
        drive(1, 4'd3, 1, 4'd0, 0, 0, 4'd3, 1, 0, 0);             expect_out("rawA_next", 0, 0, 0, 0, 1, 0, 0); step();
        drive(1, 4'd5, 0, 4'd7, 1, 1, 4'd5, 1, 0, 0);             expect_out("noRaw",     0, 0, 0, 0, 1, 0, 0); step();
        drive(1, 4'd5, 0, 4'd5, 1, 1, 4'd5, 1, 0, 0);             expect_out("rawB",      1, 0, 1, 0, 1, 0, 0); step();
        drive(1, 4'd0, 1, 4'd0, 0, 1, 4'd0, 1, 0, 0);             expect_out("rawR0",     1, 0, 1, 0, 2, 0, 0); step();
        drive(1, 4'd0, 1, 4'd0, 0, 1, 4'd0, 0, 0, 0);             expect_out("noWb",      0, 0, 0, 0, 3, 0, 0); step();
        idle();                                                   expect_out("idle2",     0, 0, 0, 0, 3, 0, 0); step();

        // Taken branch: 3 flush cycles, stallC 0->2->1->0, second branch ignored
        drive(0, 4'd0, 0, 4'd0, 0, 1, 4'd0, 0, 0, 1);             expect_out("br",        0, 0, 1, 1, 3, 0, 0); step();
        drive(0, 4'd0, 0, 4'd0, 0, 1, 4'd0, 0, 0, 1);             expect_out("brIgnored", 0, 2, 1, 1, 3, 0, 0); step();
        idle();                                                   expect_out("flush1",    0, 1, 1, 1, 3, 1, 0); step();
        idle();                                                   expect_out("flushEnd",  0, 0, 0, 0, 3, 2, 0); step();

        // Branch and RAW hazard together: flush wins, no data stall counted
        drive(1, 4'd3, 1, 4'd0, 0, 1, 4'd3, 1, 0, 1);             expect_out("brRaw",     0, 0, 1, 1, 3, 2, 0); step();
        idle();                                                   expect_out("brRaw2",    0, 2, 1, 1, 3, 2, 0); step();
        idle();                                                   expect_out("brRaw3",    0, 1, 1, 1, 3, 3, 0); step();
        idle();                                                   expect_out("brRawEnd",  0, 0, 0, 0, 3, 4, 0); step();

        // Mul/div of latency 4 with a RAW hazard pending: 3 stalls, bubbleE held low
        drive(1, 4'd3, 1, 4'd0, 0, 1, 4'd3, 1, 1, 0);             expect_out("md1",       1, 0, 0, 0, 3, 4, 0); step();
        drive(1, 4'd3, 1, 4'd0, 0, 1, 4'd3, 1, 1, 0);             expect_out("md2",       1, 0, 0, 0, 3, 4, 1); step();
        drive(1, 4'd3, 1, 4'd0, 0, 1, 4'd3, 1, 1, 0);             expect_out("md3",       1, 0, 0, 0, 3, 4, 2); step();
        drive(0, 4'd3, 1, 4'd0, 0, 1, 4'd3, 1, 1, 0);             expect_out("mdDone",    0, 0, 0, 0, 3, 4, 3); step();
        idle();                                                   expect_out("mdIdle",    0, 0, 0, 0, 3, 4, 3); step();
        chk("mdIdle/md_state", 16'(dut.md_state), 16'(MD_IDLE));

        // Reach MD_BUSY with stallC=1, then assert reset asynchronously
        drive(0, 4'd0, 0, 4'd0, 0, 1, 4'd0, 0, 0, 1);             expect_out("rBr",       0, 0, 1, 1, 3, 4, 3); step();
        drive(0, 4'd0, 0, 4'd0, 0, 1, 4'd0, 0, 1, 0);             expect_out("rMd",       0, 2, 1, 1, 3, 4, 3); step();
        idle();                                                   expect_out("rBusy",     0, 1, 1, 1, 3, 5, 3);
        #2;
        check_now();
        chk("rBusy/md_state", 16'(dut.md_state), 16'(MD_BUSY));
        reset = 1'b0;
        expect_out("rAsync", 0, 0, 0, 0, 0, 0, 0);
        #1;
        check_now();
        chk("rAsync/md_state", 16'(dut.md_state), 16'(MD_IDLE));
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        expect_out("rRelease", 0, 0, 0, 0, 0, 0, 0); step();
        chk("rRelease/md_state", 16'(dut.md_state), 16'(MD_IDLE));

        // Held RAW hazard: main counter climbs, 2-bit counter saturates at 3
        for (int i = 0; i < 5; i++) begin
            drive(1, 4'd3, 1, 4'd0, 0, 1, 4'd3, 1, 0, 0);
            expect_out($sformatf("sat%0d", i), 1, 0, 1, 0, i, 0, 0,
                       1'b1, 1'b1, (i > 3) ? 3 : i, 0);
            step();
        end

        // MULDIV_LAT=1 instance never stalls on mul/div
        drive(0, 4'd0, 0, 4'd0, 0, 1, 4'd0, 0, 1, 0);
        expect_out("lat1", 1, 0, 0, 0, 5, 0, 0, 1'b1, 1'b0, 3, 0);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
